// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_sram_responder
//  Purpose  : Responder end of the SRAM-like data interface. Accepts
//             req/addr handshakes, services them from an internal
//             word-addressed memory, and returns in-order data_ok/rdata
//             pulses after a fixed minimum latency. Up to DEPTH requests
//             may be outstanding.
//  Ports    : clk      - clock
//             reset    - asynchronous, active-high reset
//             req      - request valid
//             wr       - 1 = write, 0 = read
//             size     - access size (ignored; lanes come from wstrb)
//             wstrb    - byte write enables (writes only)
//             addr     - byte address; addr[MEM_AW+1:2] picks the word
//             wdata    - write data
//             addr_ok  - request accepted this cycle when req is high
//             data_ok  - single-cycle, in-order response pulse
//             rdata    - read data while data_ok, else 0
//  Options  : DSRAM_RAND_DELAY_EN - adds a 16-bit LFSR that stretches each
//             entry's latency by 0..3 cycles and randomly withholds addr_ok.
//  Revision : 1.0 - initial release
// ============================================================================
module data_sram_responder #(
   parameter int MEM_AW  = 10,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
`ifdef DSRAM_RAND_DELAY_EN
   localparam int c_age_w = 5;   // LATENCY (<=7) plus up to 3 extra cycles
`else
   localparam int c_age_w = 3;
`endif
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);
   localparam logic [c_age_w-1:0] c_lat   = c_age_w'(LATENCY);

   // Backing store; deliberately not reset.
   logic [31:0] mem [2**MEM_AW];

   logic [31:0]        ent_data_q [DEPTH];
   logic [31:0]        ent_data_d [DEPTH];
   logic [c_age_w-1:0] ent_age_q  [DEPTH];
   logic [c_age_w-1:0] ent_age_d  [DEPTH];
   logic [c_age_w-1:0] w_tgt      [DEPTH];
   logic [c_ptr_w-1:0] head_q, head_d;
   logic [c_ptr_w-1:0] tail_q, tail_d;
   logic [c_cnt_w-1:0] count_q, count_d;

   logic [MEM_AW-1:0]  w_word_idx;
   logic               w_accept;
   logic               w_pop;
   logic               w_gate_ok;
   logic               w_unused;

   assign w_word_idx = addr[MEM_AW+1:2];
   // Size and the non-word address bits carry no meaning for this memory.
   assign w_unused   = ^{size, addr[1:0], addr[31:MEM_AW+2]};

`ifdef DSRAM_RAND_DELAY_EN
   logic [15:0]        lfsr_q, lfsr_d;
   logic [c_age_w-1:0] ent_tgt_q [DEPTH];
   logic [c_age_w-1:0] ent_tgt_d [DEPTH];

   // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
   assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign w_gate_ok = (lfsr_q[4:2] != 3'd0);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_tgt[i]     = ent_tgt_q[i];
         ent_tgt_d[i] = ent_tgt_q[i];
      end
      if (w_accept) begin
         ent_tgt_d[tail_q] = c_lat + c_age_w'(lfsr_q[1:0]);
      end
   end
`else
   assign w_gate_ok = 1'b1;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_tgt[i] = c_lat;
      end
   end
`endif

   // No pop-credit bypass: a full queue refuses even when the head leaves.
   assign addr_ok  = !reset && (count_q < c_depth) && w_gate_ok;
   assign w_accept = req && addr_ok;
   assign data_ok  = !reset && (count_q != '0) && (ent_age_q[head_q] == w_tgt[head_q]);
   assign w_pop    = data_ok;
   assign rdata    = data_ok ? ent_data_q[head_q] : 32'd0;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      // Every entry ages each cycle and parks at its target; only the head
      // is ever allowed to respond, which keeps responses in order.
      for (int i = 0; i < DEPTH; i++) begin
         ent_data_d[i] = ent_data_q[i];
         ent_age_d[i]  = (ent_age_q[i] < w_tgt[i]) ? ent_age_q[i] + 1'b1 : ent_age_q[i];
      end
      if (w_accept) begin
         // Read data is captured at accept; a same-edge write cannot exist,
         // and earlier writes are already committed to mem.
         ent_data_d[tail_q] = wr ? 32'd0 : mem[w_word_idx];
         ent_age_d[tail_q]  = c_age_w'(1);
         tail_d             = tail_q + 1'b1;
      end
      if (w_pop) begin
         head_d = head_q + 1'b1;
      end
      case ({w_accept, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_data_q[i] <= '0;
            ent_age_q[i]  <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_data_q[i] <= ent_data_d[i];
            ent_age_q[i]  <= ent_age_d[i];
         end
      end
   end

`ifdef DSRAM_RAND_DELAY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= 16'hACE1;
         for (int i = 0; i < DEPTH; i++) begin
            ent_tgt_q[i] <= c_lat;
         end
      end else begin
         lfsr_q <= lfsr_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_tgt_q[i] <= ent_tgt_d[i];
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (w_accept && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem[w_word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_sram_responder
//  Purpose  : Self-checking bench for data_sram_responder. A queue/array
//             model tracks memory contents and outstanding requests and
//             predicts, each cycle, whether a response is due and its data.
//             Directed sequences pin literal values; a random phase follows.
//  Options  : DSRAM_RAND_DELAY_EN - widens the response window by 3 cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;

   localparam int MEM_AW = 6;
   localparam int LAT    = 5;
   localparam int DEPTH  = 4;
`ifdef DSRAM_RAND_DELAY_EN
   localparam int SLACK  = 3;
`else
   localparam int SLACK  = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = 2'd2;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   data_sram_responder #(.MEM_AW(MEM_AW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n++;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct { logic [31:0] data; int acc; bit known; } pend_t;
   typedef struct { logic [31:0] data; int acc; int ce; } resp_t;
   pend_t       q[$];
   resp_t       log_q[$];
   logic [31:0] mem_m [int];
   logic [31:0] init_val [64];
   int          last_pop = -1000;

   function automatic void check32(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   // Model + compare: runs on the falling edge, predicting the edge to come.
   always @(negedge clk) begin
      int e, occ, lo, hi, idx;
      logic [31:0] w;
      e = edge_n + 1;
      if (reset) begin
         check32("rst_addr_ok", {31'd0, addr_ok}, 32'd0);
         check32("rst_data_ok", {31'd0, data_ok}, 32'd0);
         check32("rst_rdata", rdata, 32'd0);
         q.delete();
         last_pop = edge_n;
      end else begin
         occ = q.size();
         lo = 0;
         hi = 0;
         if (occ > 0) begin
            // Response is due once the entry is old enough and the previous
            // response has gone.
            lo = q[0].acc + LAT;
            if (last_pop + 1 > lo) lo = last_pop + 1;
            hi = q[0].acc + LAT + SLACK;
            if (last_pop + 1 > hi) hi = last_pop + 1;
         end
         n_cmp++;
         if (data_ok) begin
            if (occ == 0) begin
               n_fail++;
               $display("FAIL data_ok: pulse at edge %0d with nothing outstanding", e);
            end else begin
               if (e < lo || e > hi) begin
                  n_fail++;
                  $display("FAIL resp_timing: edge %0d, required %0d..%0d", e, lo, hi);
               end
               if (q[0].known) check32("rdata", rdata, q[0].data);
               log_q.push_back('{data: rdata, acc: q[0].acc, ce: e});
               last_pop = e;
               void'(q.pop_front());
            end
         end else begin
            if (occ > 0 && e >= hi) begin
               n_fail++;
               $display("FAIL resp_missing: no data_ok at edge %0d, required by %0d", e, hi);
               last_pop = e;
               void'(q.pop_front());
            end
            check32("rdata_idle", rdata, 32'd0);
         end
`ifndef DSRAM_RAND_DELAY_EN
         check32("addr_ok", {31'd0, addr_ok}, {31'd0, (occ < DEPTH)});
`else
         if (addr_ok) check32("addr_ok_room", {31'd0, (occ < DEPTH)}, 32'd1);
`endif
         if (req && addr_ok) begin
            idx = int'(addr[MEM_AW+1:2]);
            if (wr) begin
               w = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
               for (int b = 0; b < 4; b++)
                  if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
               mem_m[idx] = w;
               q.push_back('{data: 32'd0, acc: e, known: 1'b1});
            end else begin
               q.push_back('{data: mem_m.exists(idx) ? mem_m[idx] : 32'd0,
                             acc: e, known: mem_m.exists(idx)});
            end
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 with the accept edge number.
   task automatic issue(input bit w_i, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int acc_e);
      req = 1'b1; wr = w_i; addr = a; wdata = d; wstrb = s;
      acc_e = -1;
      for (int k = 0; k < 200 && acc_e < 0; k++) begin
         @(negedge clk);
         if (addr_ok) acc_e = edge_n + 1;
         @(posedge clk);
         #1;
      end
      req = 1'b0;
      if (acc_e < 0) begin
         n_cmp++; n_fail++;
         $display("FAIL issue_timeout: addr %h never accepted", a);
      end
   endtask

   task automatic get_resp(input int a, output logic [31:0] d, output int ce);
      bit found;
      found = 1'b0; d = 32'd0; ce = -1;
      for (int k = 0; k < 80 && !found; k++) begin
         foreach (log_q[i]) if (log_q[i].acc == a) begin
            found = 1'b1; d = log_q[i].data; ce = log_q[i].ce;
         end
         if (!found) @(negedge clk);
      end
      if (!found) begin
         n_cmp++; n_fail++;
         $display("FAIL resp_wait: no response for accept edge %0d", a);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && q.size() > 0; k++) @(negedge clk);
      if (q.size() > 0) begin
         n_cmp++; n_fail++;
         $display("FAIL drain: %0d responses still outstanding", q.size());
      end
      sync();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, ce, prev_ce;
      int accs[6];
      logic [31:0] d;

      reset = 1'b1;
      #1;
      check32("reset_addr_ok", {31'd0, addr_ok}, 32'd0);
      check32("reset_data_ok", {31'd0, data_ok}, 32'd0);
      check32("reset_rdata", rdata, 32'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Give every word a known value.
      for (int i = 0; i < 64; i++) begin
         init_val[i] = $urandom;
         issue(1'b1, 32'(i * 4), init_val[i], 4'hF, a0);
      end
      drain();

      // Write then read back-to-back.
      issue(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, a0);
      issue(1'b0, 32'h40, $urandom, 4'h0, a1);
      get_resp(a0, d, ce);
      check32("write_resp_zero", d, 32'd0);
      get_resp(a1, d, ce);
      check32("read_after_write", d, 32'hDEADBEEF);
      sync();

      // Byte strobe on lane 1 only.
      issue(1'b1, 32'h40, 32'h00001100, 4'b0010, a0);
      issue(1'b0, 32'h40, 32'd0, 4'h0, a1);
      get_resp(a1, d, ce);
      check32("byte_strobe", d, 32'hDEAD11EF);
      drain();

      // Isolated read: response taken exactly LAT edges after accept.
      issue(1'b0, 32'h84, 32'd0, 4'h0, a0);
      get_resp(a0, d, ce);
      check32("latency_data", d, init_val[33]);
`ifndef DSRAM_RAND_DELAY_EN
      check32("latency_edges", 32'(ce - a0), 32'(LAT));
`endif
      drain();

      // Six back-to-back reads against a 4-deep queue.
      for (int k = 0; k < 6; k++) begin
         issue(1'b0, 32'(32'h80 + 4 * k), 32'd0, 4'h0, accs[k]);
         if (k == 3) check32("full_addr_ok_low", {31'd0, addr_ok}, 32'd0);
      end
`ifndef DSRAM_RAND_DELAY_EN
      check32("full_first4_b2b", 32'(accs[3] - accs[0]), 32'd3);
      check32("full_5th_after_pop", 32'(accs[4] - accs[0]), 32'(LAT + 1));
`endif
      prev_ce = -1;
      for (int k = 0; k < 6; k++) begin
         get_resp(accs[k], d, ce);
         check32("full_data", d, init_val[32 + k]);
         check32("full_order", {31'd0, (ce > prev_ce)}, 32'd1);
         prev_ce = ce;
      end
      drain();

      // Asynchronous reset with reads in flight.
      issue(1'b0, 32'h80, 32'd0, 4'h0, a0);
      issue(1'b0, 32'h84, 32'd0, 4'h0, a0);
      issue(1'b0, 32'h88, 32'd0, 4'h0, a0);
      for (int k = 0; k < 30 && !data_ok; k++) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check32("midreset_data_ok", {31'd0, data_ok}, 32'd0);
      check32("midreset_addr_ok", {31'd0, addr_ok}, 32'd0);
      check32("midreset_rdata", rdata, 32'd0);
      sync();
      sync();
      reset = 1'b0;
      repeat (12) sync();
      issue(1'b0, 32'h40, 32'd0, 4'h0, a0);
      get_resp(a0, d, ce);
      check32("mem_kept_over_reset", d, 32'hDEAD11EF);
      drain();

      // Random traffic, addresses alias through the upper bits.
      for (int c = 0; c < 400; c++) begin
         req   = ($urandom_range(0, 99) < 70);
         wr    = $urandom_range(0, 1) == 1;
         addr  = $urandom;
         wdata = $urandom;
         wstrb = 4'($urandom_range(0, 15));
         size  = 2'($urandom_range(0, 2));
         sync();
      end
      req = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
